// File: rtl/fp_wire.sv
// Shared FPU record types, constants and rounding-mode codes for the
// rounding/packing path.
package fp_wire;

   typedef struct packed {
      logic        sig;
      logic [13:0] expo;
      logic [53:0] mant;
      logic [1:0]  rema;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      logic [2:0]  grs;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        infs;
      logic        zero;
      logic        diff;
   } fp_rnd_in_type;

   typedef struct packed {
      logic        sig;
      logic [13:0] expo;
      logic [53:0] mant;
      logic        dbl;
      logic [2:0]  rm;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        infs;
      logic        zero;
      logic        nx;
      logic        uf;
   } fp_rnd_pipe_s1_type;

   localparam logic [31:0] FP_CANON_NAN_S = 32'h7FC0_0000;
   localparam logic [63:0] FP_CANON_NAN_D = 64'h7FF8_0000_0000_0000;
   localparam logic [13:0] FP_MAX_EXP_S   = 14'd255;
   localparam logic [13:0] FP_MAX_EXP_D   = 14'd2047;

   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RTZ = 3'd1;
   localparam logic [2:0] RDN = 3'd2;
   localparam logic [2:0] RUP = 3'd3;
   localparam logic [2:0] RMM = 3'd4;

endpackage

// File: rtl/fp_rnd_inc.sv
// Rounding increment, mantissa add and renormalisation for single or double
// precision. Purely combinational.
module fp_rnd_inc
   import fp_wire::*;
(
   input  logic        sig_i,
   input  logic        dbl_i,
   input  logic [2:0]  rm_i,
   input  logic [2:0]  grs_i,
   input  logic [13:0] expo_i,
   input  logic [53:0] mant_i,
   output logic [13:0] expo_o,
   output logic [53:0] mant_o,
   output logic        nx_o
);

   logic        inc;
   logic        hidden;
   logic [54:0] sum_d;
   logic [25:0] sum_s;

   always_comb begin
      nx_o = |grs_i;
      case (rm_i)
         RTZ:     inc = 1'b0;
         RDN:     inc = sig_i & nx_o;
         RUP:     inc = ~sig_i & nx_o;
         RMM:     inc = grs_i[2];
         default: inc = grs_i[2] & (mant_i[0] | grs_i[1] | grs_i[0]);
      endcase
      sum_d  = {1'b0, mant_i} + {54'd0, inc};
      sum_s  = {1'b0, mant_i[24:0]} + {25'd0, inc};
      expo_o = expo_i;
      // Anything at or above the carry slot means the value reached 2.0.
      if (dbl_i) begin
         if (sum_d[54] | sum_d[53]) begin
            mant_o = sum_d[54:1];
            expo_o = expo_i + 14'd1;
         end else begin
            mant_o = sum_d[53:0];
         end
         hidden = mant_o[52];
      end else begin
         if (sum_s[25] | sum_s[24]) begin
            mant_o = {29'd0, sum_s[25:1]};
            expo_o = expo_i + 14'd1;
         end else begin
            mant_o = {29'd0, sum_s[24:0]};
         end
         hidden = mant_o[23];
      end
      // Subnormal rounded up into the normal range.
      if (expo_o == 14'd0 && hidden) begin
         expo_o = 14'd1;
      end
   end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding/packing pipeline: stage 1 rounds, stage 2 classifies and
// packs the IEEE-754 result and fflags, with valid/ready on both sides.
module fp_rnd_pipe
   import fp_wire::*;
#(
   parameter int unsigned RISCV = 1,
   parameter int unsigned TAG_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  fp_rnd_in_type    fp_rnd_i,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      result,
   output logic [4:0]       flags,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [31:0] BOX = (RISCV != 0) ? 32'hFFFF_FFFF : 32'h0000_0000;

   fp_rnd_pipe_s1_type s1_d, s1_q;
   logic               s1_valid_d, s1_valid_q;
   logic [TAG_W-1:0]   s1_tag_d, s1_tag_q;
   logic               out_valid_d, out_valid_q;
   logic [63:0]        result_d, result_q;
   logic [4:0]         flags_d, flags_q;
   logic [TAG_W-1:0]   out_tag_d, out_tag_q;

   logic        s2_adv, in_fire, in_dbl, ovf, to_inf;
   logic [13:0] inc_expo;
   logic [53:0] inc_mant;
   logic        inc_nx;
   logic [31:0] s_inf, s_max, s_norm;
   logic [63:0] d_inf, d_max, d_norm;
   logic [63:0] inf_v, max_v, norm_v, zero_v, nan_v, pack;
   logic [4:0]  pack_flags;
   logic        unused_bits;

   assign in_dbl      = (fp_rnd_i.fmt == 2'd1);
   assign s2_adv      = ~out_valid_q | out_ready;
   assign in_ready    = ~s1_valid_q | s2_adv;
   assign in_fire     = in_valid & in_ready;
   assign unused_bits = ^{fp_rnd_i.rema, fp_rnd_i.diff, s1_q.mant[53:52]};

   fp_rnd_inc u_inc (
      .sig_i  (fp_rnd_i.sig),
      .dbl_i  (in_dbl),
      .rm_i   (fp_rnd_i.rm),
      .grs_i  (fp_rnd_i.grs),
      .expo_i (fp_rnd_i.expo),
      .mant_i (fp_rnd_i.mant),
      .expo_o (inc_expo),
      .mant_o (inc_mant),
      .nx_o   (inc_nx)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      s1_tag_d   = s1_tag_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
      end
      if (in_fire) begin
         s1_d.sig  = fp_rnd_i.sig;
         s1_d.expo = inc_expo;
         s1_d.mant = inc_mant;
         s1_d.dbl  = in_dbl;
         s1_d.rm   = fp_rnd_i.rm;
         s1_d.snan = fp_rnd_i.snan;
         s1_d.qnan = fp_rnd_i.qnan;
         s1_d.dbz  = fp_rnd_i.dbz;
         s1_d.infs = fp_rnd_i.infs;
         s1_d.zero = fp_rnd_i.zero;
         s1_d.nx   = inc_nx;
         s1_d.uf   = (fp_rnd_i.expo == 14'd0);
         s1_tag_d  = in_tag;
      end
      if (flush) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s_inf  = {s1_q.sig, 8'hFF, 23'd0};
      s_max  = {s1_q.sig, 8'hFE, {23{1'b1}}};
      s_norm = {s1_q.sig, s1_q.expo[7:0], s1_q.mant[22:0]};
      d_inf  = {s1_q.sig, 11'h7FF, 52'd0};
      d_max  = {s1_q.sig, 11'h7FE, {52{1'b1}}};
      d_norm = {s1_q.sig, s1_q.expo[10:0], s1_q.mant[51:0]};
      inf_v  = s1_q.dbl ? d_inf  : {BOX, s_inf};
      max_v  = s1_q.dbl ? d_max  : {BOX, s_max};
      norm_v = s1_q.dbl ? d_norm : {BOX, s_norm};
      zero_v = s1_q.dbl ? {s1_q.sig, 63'd0} : {BOX, s1_q.sig, 31'd0};
      nan_v  = s1_q.dbl ? FP_CANON_NAN_D : {BOX, FP_CANON_NAN_S};
      ovf    = $signed(s1_q.expo) >= $signed(s1_q.dbl ? FP_MAX_EXP_D : FP_MAX_EXP_S);
      case (s1_q.rm)
         RTZ:     to_inf = 1'b0;
         RDN:     to_inf = s1_q.sig;
         RUP:     to_inf = ~s1_q.sig;
         default: to_inf = 1'b1;
      endcase
      pack       = norm_v;
      pack_flags = {3'b000, s1_q.nx & s1_q.uf, s1_q.nx};
      if (s1_q.snan | s1_q.qnan) begin
         pack       = nan_v;
         pack_flags = {s1_q.snan, 4'b0000};
      end else if (s1_q.dbz) begin
         pack       = inf_v;
         pack_flags = 5'b01000;
      end else if (s1_q.infs) begin
         pack       = inf_v;
         pack_flags = 5'b00000;
      end else if (s1_q.zero) begin
         pack       = zero_v;
         pack_flags = 5'b00000;
      end else if (ovf) begin
         pack       = to_inf ? inf_v : max_v;
         pack_flags = 5'b00101;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      out_tag_d   = out_tag_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d  = pack;
            flags_d   = pack_flags;
            out_tag_d = s1_tag_q;
         end
      end
      if (flush) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign out_tag   = out_tag_q;

endmodule

// File: doc/fp_rnd_pipe.md
Name: fp_rnd_pipe

Overview:
Two-stage pipelined rounding/packing unit. It sits directly downstream of the float conversion block and consumes its fp_rnd_in_type record from the f2f or i2f path (selection is done by the FPU top). It produces the IEEE-754 packed result and the RISC-V fflags, with a valid/ready handshake on both sides, a sideband tag and a synchronous flush.

Parameters:
- RISCV, 1: when 1, single-precision results are NaN-boxed (upper 32 bits all ones); when 0, the upper 32 bits are zero.
- TAG_W, 8: width of the opaque sideband tag (rd index / ROB id) carried alongside each operation.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  fp_rnd_i and in_tag are valid.
- in_ready  out  1  stage 1 can accept this cycle.
- fp_rnd_i  in  fp_rnd_in_type  record with fields sig, expo[13:0], mant[53:0], rema, fmt, rm[2:0], grs[2:0], snan, qnan, dbz, infs, zero, diff.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result, flags and out_tag are valid.
- out_ready  in  1  consumer accepts the output.
- result  out  64  packed result (single precision in [31:0]).
- flags  out  5  {NV, DZ, OF, UF, NX}.
- out_tag  out  TAG_W  tag of the output.

Behaviour:
- Reset: s1_valid=0, out_valid=0, result=0, flags=0, out_tag=0.
- Handshake and throughput:
  - Transfer happens on valid&ready at both sides.
  - Throughput is 1 op/cycle; latency is exactly 2 cycles from input accept to out_valid when there is no backpressure.
  - s2_adv = ~out_valid | out_ready.
  - in_ready = ~s1_valid | s2_adv; it is combinational and does not depend on in_valid.
  - While out_valid & ~out_ready, result, flags and out_tag hold stable.
- Flush:
  - Next cycle s1_valid=0 and out_valid=0; datapath registers may keep stale values.
  - An input presented in the flush cycle is dropped.
  - Flush wins over reset-free accepts and over simultaneous out_ready.
- Stage 1 (increment):
  - Operation is format-sensitive. fmt==0 is single: mant[24:0] is used, hidden bit at [23], carry slot at [24]. fmt==1 is double: mant[53:0], hidden at [52], carry at [53].
  - NX_raw = |grs.
  - Increment by rm:
    - rne (0): grs[2] & (mant[0] | grs[1] | grs[0]).
    - rtz (1): 0.
    - rdn (2): sig & NX_raw.
    - rup (3): ~sig & NX_raw.
    - rmm (4): grs[2].
    - rm 5–7: treated as rne.
  - mant_r = mant + inc.
  - If the carry slot is set: mant_r >>= 1, expo += 1.
  - If expo==0 and the hidden bit of mant_r is 1 (subnormal rounded up to normal): expo = 1.
  - Register mant_r, expo, sig, fmt, rm, specials, NX_raw, the UF candidate (expo_in==0) and the tag.
- Stage 2 (classify/pack), in priority order:
  1. snan|qnan: canonical NaN (SP 0x7FC00000, DP 0x7FF8000000000000); NV = snan; other flags 0.
  2. dbz: ±inf, DZ=1.
  3. infs: ±inf, no flags.
  4. zero: signed zero using sig, no flags.
  5. Overflow, i.e. expo ≥ 255 (SP) / 2047 (DP), treated as signed:
     - OF=NX=1.
     - rne/rmm: ±inf. rtz: ±max finite.
     - rdn: +max finite or −inf.
     - rup: +inf or −max finite.
  6. Otherwise: pack {sig, expo[7:0] or [10:0], mant_r without hidden bit}; NX = NX_raw; UF = NX_raw & (expo_in==0).
- NaN-boxing: SP results are NaN-boxed per the RISCV parameter; DP uses all 64 bits.
- Width rules:
  - expo is 14-bit two's complement; a negative expo never reaches this block (the converter clamps it to 0).
  - Adders are mant width + 1.

Decomposition:
- Package fp_wire gains:
  - fp_rnd_pipe_s1_type (stage-1 register record).
  - Constants: FP_CANON_NAN_S, FP_CANON_NAN_D, FP_MAX_EXP_S=255, FP_MAX_EXP_D=2047.
  - Enum localparams for rm codes (RNE, RTZ, RDN, RUP, RMM).
- One combinational sub-module, fp_rnd_inc: increment decision, add, and renormalize. It is reused by later fused units.
- Handshake and pack logic stay in fp_rnd_pipe.

Test Plan:
- DP 1.0 (expo 1023, mant 0x10000000000000, grs 0, rne) accepted with out_ready=1 → 2 cycles later result 0x3FF0000000000000, flags 0, tag echoed.
- SP mant 0x1FFFFFF, expo 127, grs 3'b100, rne → carry renormalize: result 0xFFFFFFFF40000000 (2.0 boxed), flags NX=5'b00001.
- DP expo 2047 finite, rm rtz, sig 1 → 0xFFEFFFFFFFFFFFFF, flags 5'b00101; same input with rne → 0xFFF0000000000000.
- SP snan → 0xFFFFFFFF7FC00000, flags 5'b10000; dbz with sig 0 DP → 0x7FF0000000000000, flags 5'b01000.
- Back-to-back 4 ops with out_ready low for 3 cycles → in_ready deasserts after 2 ops buffered; outputs emerge in order, held stable while stalled, and no op is lost or duplicated.
- Flush asserted with both stages full and in_valid high → next cycle out_valid=0 and s1 empty; no flushed tag ever appears on the output.
